// File: rtl/packed_lane_assembler.sv
// Serial-to-packed lane assembler: gathers WIDTH-bit beats into a LANES-wide packed word plus tag.
// Optional build macro LANE_REVERSE_EN places beat k in lane LANES-1-k instead of lane k.
module packed_lane_assembler #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*WIDTH-1:0]       out_word,
    output logic [TAG_W-1:0]             out_tag,
    output logic [LANES*WIDTH+TAG_W-1:0] out_concat,
    output logic [$clog2(LANES+1)-1:0]   out_count
);
    localparam int CW = $clog2(LANES + 1);
    localparam int IW = $clog2(LANES);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LANES - 1);
    localparam logic [IW-1:0] TOP_LANE = IW'(LANES - 1);

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t                      r_state, w_state_nxt;
    logic [CW-1:0]               r_cnt, w_cnt_nxt;
    logic [CW-1:0]               r_ocnt, w_ocnt_nxt;
    logic [LANES-1:0][WIDTH-1:0] r_word, w_word_nxt;
    logic [TAG_W-1:0]            r_tag, w_tag_nxt;
    logic [IW-1:0]               w_idx;
    logic                        w_accept;

    // r_cnt is always 0 in HOLD, so the same lane index serves a restarting word.
`ifdef LANE_REVERSE_EN
    assign w_idx = TOP_LANE - IW'(r_cnt);
`else
    assign w_idx = IW'(r_cnt);
`endif

    assign in_ready   = (r_state == S_FILL) ? 1'b1 : out_ready;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == S_HOLD);
    assign out_word   = r_word;
    assign out_tag    = r_tag;
    assign out_concat = {r_word, r_tag};
    assign out_count  = r_ocnt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ocnt_nxt  = r_ocnt;
        w_word_nxt  = r_word;
        w_tag_nxt   = r_tag;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if (r_cnt == '0) begin
                        w_word_nxt = '0;
                        w_tag_nxt  = in_tag;
                    end
                    w_word_nxt[w_idx] = in_data;
                    if (r_cnt == LAST_CNT || in_last || flush) begin
                        w_state_nxt = S_HOLD;
                        w_ocnt_nxt  = r_cnt + ONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end else if (flush && r_cnt != '0) begin
                    w_state_nxt = S_HOLD;
                    w_ocnt_nxt  = r_cnt;
                    w_cnt_nxt   = '0;
                end
            end
            S_HOLD: begin
                // Consuming the held word and starting the next one share a cycle.
                if (out_ready) begin
                    if (in_valid) begin
                        w_word_nxt        = '0;
                        w_word_nxt[w_idx] = in_data;
                        w_tag_nxt         = in_tag;
                        if (in_last) begin
                            w_ocnt_nxt = ONE;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_state_nxt = S_FILL;
                            w_cnt_nxt   = ONE;
                        end
                    end else begin
                        w_state_nxt = S_FILL;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_ocnt  <= '0;
            r_word  <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ocnt  <= w_ocnt_nxt;
            r_word  <= w_word_nxt;
            r_tag   <= w_tag_nxt;
        end
    end
endmodule

// File: tb/tb_packed_lane_assembler.sv
// Self-checking bench for packed_lane_assembler: directed vector table, hand sequences, random scoreboard.
module tb_packed_lane_assembler;
    localparam int M_FULL  = 0;
    localparam int M_LAST  = 1;
    localparam int M_FIDLE = 2;
    localparam int M_FBEAT = 3;
`ifdef LANE_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [3:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [3:0]  out_tag;
    logic [35:0] out_concat;
    logic [2:0]  out_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0][7:0] d;
        int              n;
        int              mode;
        logic [3:0]      tag;
        logic [31:0]     exp_f;
        logic [31:0]     exp_r;
        logic [2:0]      cnt;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  tag;
        logic [2:0]  cnt;
    } wexp_t;

    vec_t  vecs [6];
    wexp_t exp_q [$];
    logic [31:0] pword;
    logic [3:0]  ptag;
    int          plen;
    int          nwords;

    packed_lane_assembler #(.LANES(4), .WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_tag(out_tag), .out_concat(out_concat), .out_count(out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int lane_of(input int k);
        return REV ? 3 - k : k;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_tag = '0; flush = 1'b0;
    endtask

    task automatic check_word(input string name, input logic [31:0] w, input logic [3:0] t,
                              input logic [2:0] c);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_word"}, out_word, w);
        chk({name, "_tag"}, out_tag, t);
        chk({name, "_count"}, out_count, c);
        chk({name, "_concat"}, out_concat, {w, t});
    endtask

    task automatic load_word(input vec_t v);
        out_ready = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            in_valid = 1'b1;
            in_data  = v.d[k];
            in_tag   = (k == 0) ? v.tag : ~v.tag;
            in_last  = (k == v.n - 1) && (v.mode == M_LAST);
            flush    = (k == v.n - 1) && (v.mode == M_FBEAT);
            #1;
            chk("pre_close_valid", out_valid, 1'b0);
            chk("fill_in_ready", in_ready, 1'b1);
            step();
        end
        idle_inputs();
        if (v.mode == M_FIDLE) begin
            flush = 1'b1;
            #1;
            chk("pre_flush_valid", out_valid, 1'b0);
            step();
            flush = 1'b0;
        end
        #1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("consumed_valid", out_valid, 1'b0);
    endtask

    task automatic pulse_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        plen = 0; pword = '0; ptag = '0; nwords = 0;
    endtask

    task automatic close_partial();
        wexp_t e;
        e.word = pword; e.tag = ptag; e.cnt = 3'(plen);
        exp_q.push_back(e);
        plen = 0;
    endtask

    // One cycle of randomized traffic scored against a transaction-level model.
    task automatic rcycle(input logic v, input logic [7:0] d, input logic l, input logic [3:0] t,
                          input logic f, input logic r);
        bit    held;
        bit    acc;
        wexp_t e;
        in_valid = v; in_data = d; in_last = l; in_tag = t; flush = f; out_ready = r;
        #1;
        held = (exp_q.size() != 0);
        chk("rnd_out_valid", out_valid, held);
        chk("rnd_in_ready", in_ready, !held || r);
        if (held && r) begin
            e = exp_q.pop_front();
            chk("rnd_word", out_word, e.word);
            chk("rnd_tag", out_tag, e.tag);
            chk("rnd_count", out_count, e.cnt);
            chk("rnd_concat", out_concat, {e.word, e.tag});
            nwords++;
        end
        acc = v && (!held || r);
        if (acc) begin
            if (plen == 0) begin
                pword = '0;
                ptag  = t;
            end
            pword[lane_of(plen)*8 +: 8] = d;
            plen++;
            if (plen == 4 || l || (f && !held)) close_partial();
        end else if (f && plen > 0) begin
            close_partial();
        end
        step();
    endtask

    initial begin
        vecs[0] = '{d: 32'h44332211, n: 4, mode: M_FULL,  tag: 4'h5,
                    exp_f: 32'h44332211, exp_r: 32'h11223344, cnt: 3'd4};
        vecs[1] = '{d: 32'h0000BBAA, n: 2, mode: M_LAST,  tag: 4'h3,
                    exp_f: 32'h0000BBAA, exp_r: 32'hAABB0000, cnt: 3'd2};
        vecs[2] = '{d: 32'h00030201, n: 3, mode: M_FIDLE, tag: 4'hA,
                    exp_f: 32'h00030201, exp_r: 32'h01020300, cnt: 3'd3};
        vecs[3] = '{d: 32'h00006655, n: 2, mode: M_FBEAT, tag: 4'hC,
                    exp_f: 32'h00006655, exp_r: 32'h55660000, cnt: 3'd2};
        vecs[4] = '{d: 32'h000000E1, n: 1, mode: M_LAST,  tag: 4'h7,
                    exp_f: 32'h000000E1, exp_r: 32'hE1000000, cnt: 3'd1};
        vecs[5] = '{d: 32'h00002211, n: 2, mode: M_LAST,  tag: 4'h1,
                    exp_f: 32'h00002211, exp_r: 32'h11220000, cnt: 3'd2};

        rst = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        plen = 0; pword = '0; ptag = '0; nwords = 0;
        @(negedge clk);
        #1;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_word", out_word, 32'h0);
        chk("reset_tag", out_tag, 4'h0);
        chk("reset_count", out_count, 3'd0);
        rst = 1'b0;
        step();

        // Reset in the middle of a word, then a full word must start from lane 0.
        in_valid = 1'b1; in_data = 8'h99; in_tag = 4'hE; step();
        in_data = 8'h98; step();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("midreset_word", out_word, 32'h0);
        chk("midreset_tag", out_tag, 4'h0);
        chk("midreset_valid", out_valid, 1'b0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            load_word(vecs[i]);
            check_word($sformatf("vec%0d", i), REV ? vecs[i].exp_r : vecs[i].exp_f,
                       vecs[i].tag, vecs[i].cnt);
            consume();
        end

        // Backpressure: word held stable, then released with a same-cycle new beat.
        load_word(vecs[0]);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = 8'h99; in_tag = 4'hF; out_ready = 1'b0;
            #1;
            chk("bp_in_ready", in_ready, 1'b0);
            check_word("bp_hold", REV ? 32'h11223344 : 32'h44332211, 4'h5, 3'd4);
            step();
        end
        in_valid = 1'b1; in_data = 8'h77; in_tag = 4'h6; out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        step();
        out_ready = 1'b0; in_data = 8'h88; in_tag = 4'h2; in_last = 1'b1;
        #1;
        chk("release_valid_drop", out_valid, 1'b0);
        chk("nobubble_in_ready", in_ready, 1'b1);
        step();
        idle_inputs();
        #1;
        check_word("after_release", REV ? 32'h77880000 : 32'h00008877, 4'h6, 3'd2);

        // Re-close in HOLD: single-beat word replaces the consumed one.
        in_valid = 1'b1; in_data = 8'h55; in_tag = 4'h9; in_last = 1'b1; out_ready = 1'b1;
        step();
        idle_inputs(); out_ready = 1'b0;
        #1;
        check_word("reclose", REV ? 32'h55000000 : 32'h00000055, 4'h9, 3'd1);
        flush = 1'b1;
        step();
        #1;
        chk("flush_in_hold_count", out_count, 3'd1);
        flush = 1'b0;
        consume();

        // Flush with an empty word must not produce output.
        flush = 1'b1;
        step();
        #1;
        chk("empty_flush_valid1", out_valid, 1'b0);
        step();
        #1;
        chk("empty_flush_valid2", out_valid, 1'b0);
        flush = 1'b0;

        // Streaming: 32 beats at one per cycle.
        pulse_reset();
        for (int i = 0; i < 32; i++)
            rcycle(1'b1, 8'($urandom), 1'b0, 4'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 2; i++)
            rcycle(1'b0, 8'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("stream_words", nwords, 8);
        chk("stream_partial", plen, 0);

        // Random valid/last/flush/ready mix.
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            logic v, l, f, r;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0);
            f = !v && ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 2) != 0);
            rcycle(v, 8'($urandom), l, 4'($urandom), f, r);
        end
        rcycle(1'b0, 8'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        rcycle(1'b0, 8'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            rcycle(1'b0, 8'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("random_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
